// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word store plus an in-order circular request buffer
// that returns each fetched word after a fixed latency, with flush and load support.
module instr_mem_responder #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_instr,
  output logic [15:0] resp_addr,
  output logic        resp_err,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam int unsigned WORDS = 2 ** (ADDR_W - 1);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned OW    = PW + 1;
  localparam int unsigned TW    = 3;

  logic [15:0]    mem_q [WORDS];

  logic [15:0]    ent_addr_q  [DEPTH];
  logic [15:0]    ent_data_q  [DEPTH];
  logic [TW-1:0]  ent_timer_q [DEPTH];
  logic [DEPTH-1:0] ent_valid_q;
  logic [DEPTH-1:0] ent_err_q;

  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [OW-1:0]  occ_q, occ_d;

  logic           accept;
  logic           pop;
  logic           head_done;
  logic [15:0]    acc_data;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{ld_addr[0], ld_addr[15:ADDR_W]};

  // Word captured at acceptance; misaligned fetches return HALT instead of memory.
  assign acc_data  = req_addr[0] ? '0 : mem_q[req_addr[ADDR_W-1:1]];

  assign head_done  = ent_valid_q[head_q] && (ent_timer_q[head_q] == '0);
  assign req_ready  = rst && (occ_q < OW'(DEPTH)) && !flush;
  assign resp_valid = rst && head_done && !flush;
  assign resp_instr = rst ? ent_data_q[head_q] : '0;
  assign resp_addr  = rst ? ent_addr_q[head_q] : '0;
  assign resp_err   = rst ? ent_err_q[head_q]  : 1'b0;

  assign accept = req_valid && req_ready;
  assign pop    = resp_valid && resp_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (accept) tail_d = tail_q + PW'(1);
      if (pop)    head_d = head_q + PW'(1);
      occ_d = occ_q + OW'(accept) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Timers run regardless of backpressure; only the head entry may retire.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      ent_valid_q <= '0;
      ent_err_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr_q[i]  <= '0;
        ent_data_q[i]  <= '0;
        ent_timer_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (accept && (tail_q == PW'(i))) begin
          ent_valid_q[i] <= 1'b1;
          ent_err_q[i]   <= req_addr[0];
          ent_addr_q[i]  <= req_addr;
          ent_data_q[i]  <= acc_data;
          ent_timer_q[i] <= TW'(LATENCY - 1);
        end else begin
          if (ent_valid_q[i] && (ent_timer_q[i] != '0))
            ent_timer_q[i] <= ent_timer_q[i] - TW'(1);
          if (pop && (head_q == PW'(i)))
            ent_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ld_en)
      mem_q[ld_addr[ADDR_W-1:1]] <= ld_data;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_instr_mem_responder;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned WORDS   = 2 ** (ADDR_W - 1);

  logic        clk = 1'b0;
  logic        rst, req_valid, resp_ready, flush, ld_en;
  logic [15:0] req_addr, ld_addr, ld_data;
  logic        req_ready, resp_valid, resp_err;
  logic [15:0] resp_instr, resp_addr;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .ADDR_W(ADDR_W),
    .LATENCY(LATENCY),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_instr(resp_instr),
    .resp_addr(resp_addr),
    .resp_err(resp_err),
    .flush(flush),
    .ld_en(ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
    int unsigned acc;
  } ent_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        err;
  } rsp_t;

  ent_t        q[$];
  rsp_t        got[$];
  logic [15:0] mem_m [WORDS];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        post_rst = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    logic exp_rdy, exp_vld;
    ent_t e;
    rsp_t r;
    @(negedge clk);
    exp_rdy = rst && (q.size() < DEPTH) && !flush;
    exp_vld = rst && !flush && (q.size() > 0) && ((cyc - q[0].acc) >= LATENCY - 1);
    chk("req_ready", {15'b0, req_ready}, {15'b0, exp_rdy});
    chk("resp_valid", {15'b0, resp_valid}, {15'b0, exp_vld});
    if (exp_vld) begin
      chk("resp_instr", resp_instr, q[0].data);
      chk("resp_addr", resp_addr, q[0].addr);
      chk("resp_err", {15'b0, resp_err}, {15'b0, q[0].err});
    end else if (!rst || post_rst) begin
      chk("rst_instr", resp_instr, 16'h0000);
      chk("rst_addr", resp_addr, 16'h0000);
      chk("rst_err", {15'b0, resp_err}, 16'h0000);
    end
    if (rst && !flush && resp_valid && resp_ready) begin
      r.addr = resp_addr; r.instr = resp_instr; r.err = resp_err;
      got.push_back(r);
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      q.delete();
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (exp_vld && resp_ready) void'(q.pop_front());
        if (exp_rdy && req_valid) begin
          e.addr = req_addr;
          e.err  = req_addr[0];
          e.data = req_addr[0] ? 16'h0000 : mem_m[req_addr[ADDR_W-1:1]];
          e.acc  = cyc;
          q.push_back(e);
        end
      end
      if (ld_en) mem_m[ld_addr[ADDR_W-1:1]] = ld_data;
    end
    #1;
  endtask

  task automatic expect_rsp(input string tag, input int unsigned idx,
                            input logic [15:0] a, input logic [15:0] d, input logic e);
    if (idx < got.size()) begin
      chk({tag, "_addr"}, got[idx].addr, a);
      chk({tag, "_instr"}, got[idx].instr, d);
      chk({tag, "_err"}, {15'b0, got[idx].err}, {15'b0, e});
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    cycle();
    ld_en = 1'b0;
  endtask

  task automatic request(input logic [15:0] a);
    req_valid = 1'b1; req_addr = a;
    cycle();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0; ld_en = 1'b0;
    req_addr = '0; ld_addr = '0; ld_data = '0;
    repeat (2) cycle();
    rst = 1'b1;

    for (int unsigned i = 0; i < WORDS; i++) load(16'(2 * i), 16'($urandom));
    load(16'h0000, 16'h1111);
    load(16'h0002, 16'h2222);
    load(16'h0004, 16'h3333);
    load(16'h0006, 16'h4444);

    // Back-to-back stream
    got.delete();
    resp_ready = 1'b1;
    req_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      req_addr = 16'(2 * i);
      cycle();
    end
    req_valid = 1'b0;
    repeat (4) cycle();
    chk("stream_count", 16'(got.size()), 16'd4);
    expect_rsp("stream0", 0, 16'h0000, 16'h1111, 1'b0);
    expect_rsp("stream1", 1, 16'h0002, 16'h2222, 1'b0);
    expect_rsp("stream2", 2, 16'h0004, 16'h3333, 1'b0);
    expect_rsp("stream3", 3, 16'h0006, 16'h4444, 1'b0);

    // Backpressure: fifth request must stall, head stays stable
    got.delete();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      req_addr = 16'(2 * (i % 4));
      cycle();
    end
    req_valid = 1'b0;
    repeat (3) cycle();
    resp_ready = 1'b1;
    repeat (6) cycle();
    chk("bp_count", 16'(got.size()), 16'd4);
    expect_rsp("bp0", 0, 16'h0000, 16'h1111, 1'b0);
    expect_rsp("bp3", 3, 16'h0006, 16'h4444, 1'b0);

    // Misaligned fetch then aligned
    got.delete();
    request(16'h0003);
    request(16'h0004);
    repeat (4) cycle();
    chk("mis_count", 16'(got.size()), 16'd2);
    expect_rsp("mis0", 0, 16'h0003, 16'h0000, 1'b1);
    expect_rsp("mis1", 1, 16'h0004, 16'h3333, 1'b0);

    // Flush discards outstanding requests
    got.delete();
    request(16'h0000);
    request(16'h0002);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    request(16'h0006);
    repeat (4) cycle();
    chk("flush_count", 16'(got.size()), 16'd1);
    expect_rsp("flush0", 0, 16'h0006, 16'h4444, 1'b0);

    // Snapshot semantics and aliasing
    got.delete();
    request(16'h0002);
    load(16'h0002, 16'hBEEF);
    repeat (3) cycle();
    request(16'h0002);
    request(16'h0202);
    req_valid = 1'b1; req_addr = 16'h0004;
    ld_en = 1'b1; ld_addr = 16'h0004; ld_data = 16'hCAFE;
    cycle();
    ld_en = 1'b0;
    req_addr = 16'h0004;
    cycle();
    req_valid = 1'b0;
    repeat (4) cycle();
    chk("snap_count", 16'(got.size()), 16'd5);
    expect_rsp("snap0", 0, 16'h0002, 16'h2222, 1'b0);
    expect_rsp("snap1", 1, 16'h0002, 16'hBEEF, 1'b0);
    expect_rsp("snap2", 2, 16'h0202, 16'hBEEF, 1'b0);
    expect_rsp("snap3", 3, 16'h0004, 16'h3333, 1'b0);
    expect_rsp("snap4", 4, 16'h0004, 16'hCAFE, 1'b0);

    // Reset mid-stream with entries in flight; store survives, load in reset ignored
    got.delete();
    resp_ready = 1'b0;
    request(16'h0000);
    request(16'h0004);
    request(16'h0006);
    rst = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0002;
    ld_en = 1'b1; ld_addr = 16'h0000; ld_data = 16'hDEAD;
    repeat (2) cycle();
    rst = 1'b1; req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
    repeat (4) cycle();
    chk("rst_stale", 16'(got.size()), 16'd0);
    request(16'h0000);
    repeat (3) cycle();
    chk("rst_count", 16'(got.size()), 16'd1);
    expect_rsp("rst0", 0, 16'h0000, 16'h1111, 1'b0);

    // Random traffic against the model
    for (int unsigned i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 99) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = 16'($urandom);
      if ($urandom_range(0, 9) != 0) req_addr[0] = 1'b0;
      resp_ready = ($urandom_range(0, 3) != 0);
      ld_en      = ($urandom_range(0, 7) == 0);
      ld_addr    = 16'($urandom);
      ld_data    = 16'($urandom);
      cycle();
    end
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Responder side of the instruction-fetch interface: accepts fetch-address requests from the fetch stage and returns the addressed 16-bit instruction after a fixed, parameterised latency. Requests are tracked in an in-order circular buffer, so several fetches can be in flight and completed responses are held under fetch-side backpressure. A flush input discards all outstanding requests on redirect or exception. A load port fills the instruction store before and between runs.

## Interface
- ADDR_W, 9: byte-address bits decoded; store holds 2^(ADDR_W-1) 16-bit words.
- LATENCY, 2: cycles from request acceptance to response valid; legal 1..4.
- DEPTH, 4: buffer entries (accepted, not yet consumed); power of 2, ≥2. Full throughput requires DEPTH ≥ LATENCY+1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  fetch presents an address.
- req_ready  out  1  responder can accept.
- req_addr  in  16  byte address of the instruction.
- resp_valid  out  1  head response is available.
- resp_ready  in  1  fetch consumes the head response.
- resp_instr  out  16  instruction word.
- resp_addr  out  16  address the response belongs to.
- resp_err  out  1  request address was misaligned.
- flush  in  1  discard all outstanding requests.
- ld_en  in  1  write the store.
- ld_addr  in  16  byte address for the load; bit 0 ignored.
- ld_data  in  16  word to write.

## Operation
- Store: 2^(ADDR_W-1) x 16 words, indexed by addr[ADDR_W-1:1]. Upper address bits are ignored, so addresses alias modulo 2^ADDR_W. Contents are not cleared by reset.
- Accept: on a rising edge with req_valid & req_ready & !flush, the tail entry is written with:
  - addr = req_addr;
  - data = store word read in that cycle, or 16'h0000 (HALT) if req_addr[0] = 1;
  - err = req_addr[0];
  - timer = LATENCY-1.
  The tail pointer then increments, wrapping modulo DEPTH.
- Snapshot: data is captured at acceptance. A later ld_en to the same word does not change an in-flight entry. When ld_en and accept hit the same word in the same cycle, the entry gets the old word and the store gets the new one.
- Timer: every valid entry with timer > 0 decrements each cycle, independent of backpressure.
- Response: resp_valid = head entry valid & head timer == 0 & !flush. resp_instr, resp_addr and resp_err show the head entry's fields.
- Pop: on an edge with resp_valid & resp_ready, the head entry is invalidated and the head pointer increments modulo DEPTH.
- Ordering: responses are strictly in request order. A younger entry never overtakes an older one, even if the younger one's timer has expired.
- Occupancy: count of valid entries, 0..DEPTH. req_ready = rst & (occupancy < DEPTH) & !flush. An accept and a pop in the same cycle leave occupancy unchanged. There is no pass-through when full: req_ready stays 0 even if a pop occurs that cycle.
- Flush: priority over accept and pop. In a flush cycle, req_ready = 0 and resp_valid = 0. At the edge, all entries are invalidated, head = tail = 0 and occupancy = 0. ld_en is still honoured.
- Reset (rst = 0 at an edge): all entries invalid, pointers and occupancy 0. Any in-flight requests are lost. A load in the same cycle is ignored.

## Timing
- Outputs while rst = 0 and in the first cycle after: req_ready = 0 during reset, 1 after; resp_valid 0; resp_instr 16'h0000; resp_addr 16'h0000; resp_err 0.
- Request accepted at edge N gives resp_valid high in the cycle after edge N+LATENCY-1 (the earliest). With LATENCY = 1, it is valid in the cycle right after acceptance.
- Sustained throughput is 1 response/cycle when DEPTH ≥ LATENCY+1 and resp_ready is held at 1.
- A response held under backpressure keeps resp_instr, resp_addr and resp_err stable until popped or flushed.
- Flush asserted in cycle F: the first new request can be accepted in cycle F+1, and its response becomes valid LATENCY cycles after that.
- A load at edge N is visible to requests accepted in cycle N+1 or later.

## Test plan
- Load 0x0000–0x0006 with 0x1111, 0x2222, 0x3333, 0x4444. Stream requests at 0x0000, 0x0002, 0x0004, 0x0006 back-to-back with resp_ready = 1 (LATENCY = 2, DEPTH = 4) -> responses in consecutive cycles, 2 cycles after each accept, in order, resp_err = 0.
- Hold resp_ready = 0 and issue 5 requests -> 4 accepted, then req_ready = 0. Head holds 0x1111/0x0000 stable. Releasing resp_ready drains 4 responses in order, and req_ready returns to 1 the cycle after the first pop.
- Request 0x0003 -> resp_err = 1, resp_instr = 0x0000, resp_addr = 0x0003. The next aligned request returns normal data.
- Accept two requests, then assert flush for 1 cycle while the first is still pending -> no response for either. A request in the following cycle returns correct data after LATENCY cycles.
- Accept 0x0002, then ld 0x0002 = 0xBEEF next cycle -> response is 0x2222. A new request to 0x0002 returns 0xBEEF. A request to 0x0202 (alias) also returns 0xBEEF.
- Pull rst low mid-stream with 3 entries in flight -> resp_valid = 0 and req_ready = 0 during reset. After reset, occupancy is 0 and no stale responses appear. Store contents are preserved.
